// File: rtl/axi_common_types_pkg.sv
// Shared AXI field widths, BURST/RESP encodings and FSM state types for the
// s6_modport responder slice.
package axi_common_types_pkg;

    localparam int AXI_LEN_W   = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {W_RST, W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_RST, R_IDLE, R_DATA} rd_state_e;

    // A burst the responder cannot serve: reserved type, beat wider than the
    // bus, or a WRAP whose length is not 2/4/8/16 beats.
    function automatic logic burst_illegal(input logic [AXI_BURST_W-1:0] burst,
                                           input logic [AXI_SIZE_W-1:0]  size,
                                           input logic [AXI_LEN_W-1:0]   len,
                                           input int                     bytes_log2);
        logic wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (burst == BURST_RSVD) || (int'(size) > bytes_log2) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for an AXI burst: FIXED holds, INCR steps by the beat
// size, WRAP steps within the (LEN+1)*beat aligned window.
module axi_burst_addr_gen
    import axi_common_types_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [AXI_LEN_W-1:0]   len,
    input  logic [AXI_SIZE_W-1:0]  size,
    input  logic [AXI_BURST_W-1:0] burst,
    output logic [ADDR_W-1:0]      next_addr
);

    logic [ADDR_W-1:0] beat_bytes;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr_addr;

    always_comb begin
        beat_bytes = ADDR_W'(1) << size;
        wrap_mask  = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        incr_addr  = addr + beat_bytes;
        case (axi_burst_e'(burst))
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/s6_modport.sv
// AXI slave responder over a MEM_WORDS x DATA_W memory with independent,
// single-outstanding write and read FSMs.
module s6_modport
    import axi_common_types_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [ID_W-1:0]        AWID,
    input  logic [ADDR_W-1:0]      AWADDR,
    input  logic [3:0]             AWLEN,
    input  logic [2:0]             AWSIZE,
    input  logic [1:0]             AWBURST,
    input  logic                   AWLOCK,
    input  logic [3:0]             AWCACHE,
    input  logic [2:0]             AWPROT,
    input  logic [3:0]             AWQOS,
    input  logic [3:0]             AWREGION,
    input  logic                   AWUSER,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [DATA_W-1:0]      WDATA,
    input  logic [DATA_W/8-1:0]    WSTRB,
    input  logic                   WLAST,
    input  logic                   WUSER,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic [ID_W-1:0]        BID,
    output logic [1:0]             BRESP,
    output logic                   BVALID,
    output logic                   BUSER,
    input  logic                   BREADY,
    input  logic [ID_W-1:0]        ARID,
    input  logic [ADDR_W-1:0]      ARADDR,
    input  logic [3:0]             ARLEN,
    input  logic [2:0]             ARSIZE,
    input  logic [1:0]             ARBURST,
    input  logic                   ARLOCK,
    input  logic [3:0]             ARCACHE,
    input  logic [2:0]             ARPROT,
    input  logic [3:0]             ARQOS,
    input  logic [3:0]             ARREGION,
    input  logic                   ARUSER,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    output logic [ID_W-1:0]        RID,
    output logic [DATA_W-1:0]      RDATA,
    output logic [1:0]             RRESP,
    output logic                   RLAST,
    output logic                   RVALID,
    output logic                   RUSER,
    input  logic                   RREADY
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_WORDS);

    logic unused_sideband;
    assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, AWUSER, WUSER,
                               ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, ARUSER};

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [DATA_W-1:0] rd_q_reg;

    // ---------------- write path ----------------
    wr_state_e         w_state_reg, w_state_next;
    logic [ID_W-1:0]   aw_id_reg;
    logic [ADDR_W-1:0] aw_addr_reg, w_next_addr;
    logic [3:0]        aw_len_reg, w_cnt_reg;
    logic [2:0]        aw_size_reg;
    logic [1:0]        aw_burst_reg;
    logic              aw_bad_reg, b_err_reg;
    logic              w_at_len, w_beat_last, mem_we;
    logic [IDX_W-1:0]  w_idx;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
        .addr(aw_addr_reg), .len(aw_len_reg), .size(aw_size_reg),
        .burst(aw_burst_reg), .next_addr(w_next_addr)
    );

    assign w_at_len    = (w_cnt_reg == aw_len_reg);
    assign w_beat_last = WLAST || w_at_len;
    assign mem_we      = (w_state_reg == W_DATA) && WVALID && !aw_bad_reg;
    assign w_idx       = aw_addr_reg[BYTE_LSB +: IDX_W];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state_reg <= W_RST;
        else        w_state_reg <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_RST:   w_state_next = W_IDLE;
            W_IDLE:  if (AWVALID) w_state_next = W_DATA;
            W_DATA:  if (WVALID && w_beat_last) w_state_next = W_RESP;
            W_RESP:  if (BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_RST;
        endcase
    end

    always_comb begin
        AWREADY = (w_state_reg == W_IDLE);
        WREADY  = (w_state_reg == W_DATA);
        BVALID  = (w_state_reg == W_RESP);
        BID     = aw_id_reg;
        BRESP   = (BVALID && b_err_reg) ? RESP_SLVERR : RESP_OKAY;
        BUSER   = 1'b0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_id_reg    <= '0;
            aw_addr_reg  <= '0;
            aw_len_reg   <= '0;
            aw_size_reg  <= '0;
            aw_burst_reg <= '0;
            aw_bad_reg   <= 1'b0;
            b_err_reg    <= 1'b0;
            w_cnt_reg    <= '0;
        end else if (w_state_reg == W_IDLE && AWVALID) begin
            aw_id_reg    <= AWID;
            aw_addr_reg  <= AWADDR;
            aw_len_reg   <= AWLEN;
            aw_size_reg  <= AWSIZE;
            aw_burst_reg <= AWBURST;
            aw_bad_reg   <= burst_illegal(AWBURST, AWSIZE, AWLEN, BYTE_LSB);
            b_err_reg    <= burst_illegal(AWBURST, AWSIZE, AWLEN, BYTE_LSB);
            w_cnt_reg    <= '0;
        end else if (w_state_reg == W_DATA && WVALID) begin
            aw_addr_reg <= w_next_addr;
            w_cnt_reg   <= w_cnt_reg + 4'd1;
            // WLAST and the beat count must agree on which beat ends the burst
            if (WLAST != w_at_len) b_err_reg <= 1'b1;
        end
    end

    // ---------------- read path ----------------
    rd_state_e         r_state_reg, r_state_next;
    logic [ID_W-1:0]   ar_id_reg;
    logic [ADDR_W-1:0] ar_addr_reg, r_next_addr;
    logic [3:0]        ar_len_reg, r_cnt_reg;
    logic [2:0]        ar_size_reg;
    logic [1:0]        ar_burst_reg;
    logic              r_err_reg, r_last, rd_en;
    logic [IDX_W-1:0]  r_idx;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
        .addr(ar_addr_reg), .len(ar_len_reg), .size(ar_size_reg),
        .burst(ar_burst_reg), .next_addr(r_next_addr)
    );

    assign r_last = (r_cnt_reg == ar_len_reg);
    // Fetch the first beat on the AR handshake, later beats on each R handshake
    assign rd_en  = ((r_state_reg == R_IDLE) && ARVALID) ||
                    ((r_state_reg == R_DATA) && RREADY && !r_last);
    assign r_idx  = (r_state_reg == R_IDLE) ? ARADDR[BYTE_LSB +: IDX_W]
                                            : r_next_addr[BYTE_LSB +: IDX_W];

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state_reg <= R_RST;
        else        r_state_reg <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_RST:   r_state_next = R_IDLE;
            R_IDLE:  if (ARVALID) r_state_next = R_DATA;
            R_DATA:  if (RREADY && r_last) r_state_next = R_IDLE;
            default: r_state_next = R_RST;
        endcase
    end

    always_comb begin
        ARREADY = (r_state_reg == R_IDLE);
        RVALID  = (r_state_reg == R_DATA);
        RLAST   = RVALID && r_last;
        RID     = ar_id_reg;
        RDATA   = (RVALID && !r_err_reg) ? rd_q_reg : '0;
        RRESP   = (RVALID && r_err_reg) ? RESP_SLVERR : RESP_OKAY;
        RUSER   = 1'b0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ar_id_reg    <= '0;
            ar_addr_reg  <= '0;
            ar_len_reg   <= '0;
            ar_size_reg  <= '0;
            ar_burst_reg <= '0;
            r_err_reg    <= 1'b0;
            r_cnt_reg    <= '0;
        end else if (r_state_reg == R_IDLE && ARVALID) begin
            ar_id_reg    <= ARID;
            ar_addr_reg  <= ARADDR;
            ar_len_reg   <= ARLEN;
            ar_size_reg  <= ARSIZE;
            ar_burst_reg <= ARBURST;
            r_err_reg    <= burst_illegal(ARBURST, ARSIZE, ARLEN, BYTE_LSB);
            r_cnt_reg    <= '0;
        end else if (r_state_reg == R_DATA && RREADY && !r_last) begin
            ar_addr_reg <= r_next_addr;
            r_cnt_reg   <= r_cnt_reg + 4'd1;
        end
    end

    // Memory is never reset; the read sees pre-write data on a same-word collision
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
        if (rd_en) rd_q_reg <= mem[r_idx];
    end

endmodule

// File: tb/tb_s6_modport.sv
// Directed bench for s6_modport: reset, INCR/WRAP/strobe traffic, illegal
// bursts, read back-pressure and reset mid-burst.
module tb_s6_modport;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY, BUSER;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, RUSER;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [1:0]  rd_resp [16];
    logic [3:0]  rd_id   [16];
    logic [3:0]  b_id_got;
    logic [1:0]  b_resp_got;

    always #5 ACLK = ~ACLK;

    s6_modport dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(1'b0), .AWCACHE(4'h0), .AWPROT(3'h0), .AWQOS(4'h0), .AWREGION(4'h0),
        .AWUSER(1'b0), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(1'b0), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BUSER(BUSER), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(1'b1), .ARCACHE(4'h0), .ARPROT(3'h0), .ARQOS(4'h0), .ARREGION(4'h0),
        .ARUSER(1'b0), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RUSER(RUSER), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Starts and ends just after a falling edge.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [3:0] strb, input int nbeats);
        int t;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 20) begin @(negedge ACLK); t++; end
        chk("aw_wait", {31'b0, t < 20}, 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            WDATA = wr_data[b]; WSTRB = strb; WLAST = (b == nbeats - 1); WVALID = 1'b1;
            t = 0;
            while (!WREADY && t < 20) begin @(negedge ACLK); t++; end
            chk("w_wait", {31'b0, t < 20}, 32'd1);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        t = 0;
        while (!BVALID && t < 20) begin @(negedge ACLK); t++; end
        chk("b_wait", {31'b0, t < 20}, 32'd1);
        b_id_got = BID; b_resp_got = BRESP;
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("b_done", {31'b0, BVALID}, 32'd0);
        $display("WRITE id=%0h addr=%08h len=%0d burst=%0d strb=%0h -> bid=%0h bresp=%0d",
                 id, addr, len, burst, strb, b_id_got, b_resp_got);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall, input logic [31:0] exp_stall);
        int t;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < 20) begin @(negedge ACLK); t++; end
        chk("ar_wait", {31'b0, t < 20}, 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("rvalid_first", {31'b0, RVALID}, 32'd1);
        RREADY = (stall == 0);
        for (int i = 0; i < stall; i++) begin
            chk("stall_rvalid", {31'b0, RVALID}, 32'd1);
            chk("stall_rdata", RDATA, exp_stall);
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!RVALID && t < 20) begin @(negedge ACLK); t++; end
            chk("r_wait", {31'b0, t < 20}, 32'd1);
            rd_data[b] = RDATA; rd_last[b] = RLAST; rd_resp[b] = RRESP; rd_id[b] = RID;
            @(negedge ACLK);
        end
        RREADY = 1'b0;
        chk("rvalid_idle", {31'b0, RVALID}, 32'd0);
        $display("READ  id=%0h addr=%08h len=%0d burst=%0d -> first=%08h resp=%0d",
                 id, addr, len, burst, rd_data[0], rd_resp[0]);
    endtask

    task automatic check_read(input string tag, input int n,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic [1:0] resp, input logic [3:0] id);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int b = 0; b < n; b++) begin
            chk({tag, "_data"}, rd_data[b], e[b]);
            chk({tag, "_last"}, {31'b0, rd_last[b]}, {31'b0, b == n - 1});
            chk({tag, "_resp"}, {30'b0, rd_resp[b]}, {30'b0, resp});
        end
        chk({tag, "_id"}, {28'b0, rd_id[0]}, {28'b0, id});
    endtask

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        // Reset state
        repeat (2) @(negedge ACLK);
        chk("rst_awready", {31'b0, AWREADY}, 32'd0);
        chk("rst_wready",  {31'b0, WREADY},  32'd0);
        chk("rst_arready", {31'b0, ARREADY}, 32'd0);
        chk("rst_bvalid",  {31'b0, BVALID},  32'd0);
        chk("rst_bid",     {28'b0, BID},     32'd0);
        chk("rst_bresp",   {30'b0, BRESP},   32'd0);
        chk("rst_rvalid",  {31'b0, RVALID},  32'd0);
        chk("rst_rlast",   {31'b0, RLAST},   32'd0);
        chk("rst_rid",     {28'b0, RID},     32'd0);
        chk("rst_rdata",   RDATA,            32'd0);
        chk("rst_rresp",   {30'b0, RRESP},   32'd0);
        chk("rst_users",   {30'b0, BUSER, RUSER}, 32'd0);
        ARESET = 1'b0;
        #1;
        chk("rel_awready_pre", {31'b0, AWREADY}, 32'd0);
        @(negedge ACLK);
        chk("rel_awready", {31'b0, AWREADY}, 32'd1);
        chk("rel_arready", {31'b0, ARREADY}, 32'd1);

        // INCR write then read back
        wr_data[0] = 32'hA0; wr_data[1] = 32'hA1; wr_data[2] = 32'hA2; wr_data[3] = 32'hA3;
        do_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 4'hF, 4);
        chk("incr_bid", {28'b0, b_id_got}, 32'd5);
        chk("incr_bresp", {30'b0, b_resp_got}, 32'd0);
        do_read(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 0, 32'h0);
        check_read("incr_rd", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00, 4'd5);

        // Partial strobe
        wr_data[0] = 32'hFFFF_FFFF;
        do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 4'hF, 1);
        wr_data[0] = 32'h1122_3344;
        do_write(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 4'h3, 1);
        chk("strb_bresp", {30'b0, b_resp_got}, 32'd0);
        do_read(4'd2, 32'h40, 4'd0, 3'd2, 2'b01, 0, 32'h0);
        check_read("strb_rd", 1, 32'hFFFF_3344, 32'h0, 32'h0, 32'h0, 2'b00, 4'd2);

        // WRAP read from 0x0C visits 0x0C, 0x00, 0x04, 0x08
        wr_data[0] = 32'hB0; wr_data[1] = 32'hB1; wr_data[2] = 32'hB2; wr_data[3] = 32'hB3;
        do_write(4'd3, 32'h00, 4'd3, 3'd2, 2'b01, 4'hF, 4);
        do_read(4'd3, 32'h0C, 4'd3, 3'd2, 2'b10, 0, 32'h0);
        check_read("wrap_rd", 4, 32'hB3, 32'hB0, 32'hB1, 32'hB2, 2'b00, 4'd3);

        // Reserved write burst: full length accepted, memory untouched
        wr_data[0] = 32'hDEAD_0001; wr_data[1] = 32'hDEAD_0002;
        do_write(4'd6, 32'h10, 4'd1, 3'd2, 2'b11, 4'hF, 2);
        chk("rsvd_bid", {28'b0, b_id_got}, 32'd6);
        chk("rsvd_bresp", {30'b0, b_resp_got}, 32'd2);
        do_read(4'd7, 32'h10, 4'd1, 3'd2, 2'b01, 5, 32'hA0);
        check_read("stall_rd", 2, 32'hA0, 32'hA1, 32'h0, 32'h0, 2'b00, 4'd7);

        // Illegal read bursts return zero data with SLVERR throughout
        do_read(4'd8, 32'h10, 4'd1, 3'd2, 2'b11, 0, 32'h0);
        check_read("rsvd_rd", 2, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 4'd8);
        do_read(4'd9, 32'h10, 4'd0, 3'd3, 2'b01, 0, 32'h0);
        check_read("size_rd", 1, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 4'd9);
        do_read(4'd10, 32'h10, 4'd2, 3'd2, 2'b10, 0, 32'h0);
        check_read("wraplen_rd", 3, 32'h0, 32'h0, 32'h0, 32'h0, 2'b10, 4'd10);

        // Early WLAST: write still lands, response is SLVERR
        wr_data[0] = 32'hC0;
        do_write(4'd4, 32'h60, 4'd1, 3'd2, 2'b01, 4'hF, 1);
        chk("early_bresp", {30'b0, b_resp_got}, 32'd2);
        do_read(4'd4, 32'h60, 4'd0, 3'd2, 2'b01, 0, 32'h0);
        check_read("early_rd", 1, 32'hC0, 32'h0, 32'h0, 32'h0, 2'b00, 4'd4);

        // Reset pulse during beat 2 of a 4-beat read
        ARID = 4'd1; ARADDR = 32'h10; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
        ARVALID = 1'b1;
        chk("mid_arready", {31'b0, ARREADY}, 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b1;
        chk("mid_beat1", RDATA, 32'hA0);
        @(negedge ACLK);
        chk("mid_beat2", RDATA, 32'hA1);
        #2 ARESET = 1'b1;
        #1;
        chk("mid_rvalid", {31'b0, RVALID}, 32'd0);
        chk("mid_rlast", {31'b0, RLAST}, 32'd0);
        chk("mid_rdata", RDATA, 32'd0);
        chk("mid_arready_rst", {31'b0, ARREADY}, 32'd0);
        RREADY = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("mid_arready_rel", {31'b0, ARREADY}, 32'd1);
        chk("mid_awready_rel", {31'b0, AWREADY}, 32'd1);
        do_read(4'd2, 32'h10, 4'd3, 3'd2, 2'b01, 0, 32'h0);
        check_read("post_rst_rd", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00, 4'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
